// File: rtl/uart_calc_ctrl_if.sv
// Byte-stream bundle between the UART core side and the calculator controller.
//   rx_data/rx_valid : received byte and its one-cycle qualifier
//   tx_data/tx_valid : byte to transmit and its one-cycle frame-start pulse
//   busy             : controller is computing or transmitting a result
//   rx_drop          : one-cycle pulse when a received byte was discarded
// modport slave is the controller; modport master is the UART/stimulus side.
interface uart_calc_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic       rx_drop;

   modport master (
      output rx_data, rx_valid,
      input  tx_data, tx_valid, busy, rx_drop
   );

   modport slave (
      input  rx_data, rx_valid,
      output tx_data, tx_valid, busy, rx_drop
   );
endinterface

// File: rtl/uart_calc_ctrl.sv
// Parses one ASCII expression "A op B<term>" from the received byte stream, evaluates it and
// transmits the result as ASCII decimal followed by CR LF (or "E" CR LF on a malformed line).
// Transmit bytes are self-paced BYTE_CYCLES apart since the tx path has no ready.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : uart_calc_ctrl_if slave (rx_data/rx_valid in, tx_data/tx_valid/busy/rx_drop out)
module uart_calc_ctrl #(
   parameter int unsigned BYTE_CYCLES = 104170
) (
   input logic            clk,
   input logic            n_rst,
   uart_calc_ctrl_if.slave bus
);

   localparam logic [31:0] GapReload = 32'(BYTE_CYCLES - 1);

   typedef enum logic [2:0] {StA, StB, StSkip, StCalc, StConv, StSend} state_e;
   typedef enum logic [2:0] {ActNone, ActDigit, ActOp, ActCalc, ActSkip, ActErrOut} act_e;

   state_e             state_q;
   logic [7:0]         a_q, b_q;
   logic [1:0]         a_cnt_q, b_cnt_q;
   logic [1:0]         op_q;
   logic signed [16:0] res_q;
   logic [16:0]        mag_q;
   logic [2:0]         place_q;
   logic [3:0]         digit_q;
   logic               started_q;
   logic [7:0]         tx_buf_q [8];
   logic [3:0]         len_q, idx_q;
   logic [31:0]        gap_q;
   logic [7:0]         tx_data_q;
   logic               tx_valid_q, busy_q, rx_drop_q;

   // Received byte classification
   logic [7:0] rx;
   logic       is_digit, is_op, is_term, is_space;
   logic [1:0] op_code;
   assign rx       = bus.rx_data;
   assign is_digit = (rx >= 8'h30) && (rx <= 8'h39);
   assign is_op    = (rx == 8'h2B) || (rx == 8'h2D) || (rx == 8'h2A);
   assign is_term  = (rx == 8'h0D) || (rx == 8'h3D);
   assign is_space = (rx == 8'h20);
   assign op_code  = (rx == 8'h2B) ? 2'd0 : (rx == 8'h2D) ? 2'd1 : 2'd2;

   // Accumulator of the operand currently being parsed; a 4th digit never reaches the
   // multiply, so 10 bits cover every checked value (max 99*10+9).
   logic [7:0] acc;
   logic [1:0] cnt;
   logic [9:0] acc_next;
   logic       digit_err;
   assign acc       = (state_q == StB) ? b_q : a_q;
   assign cnt       = (state_q == StB) ? b_cnt_q : a_cnt_q;
   assign acc_next  = ({2'b00, acc} * 10'd10) + {6'd0, rx[3:0]};
   assign digit_err = (cnt == 2'd3) || (acc_next > 10'd255);

   act_e act;
   always_comb begin
      act = ActNone;
      if (bus.rx_valid && !busy_q) begin
         case (state_q)
            StA, StB: begin
               if (is_space) begin
                  act = ActNone;
               end else if (is_digit) begin
                  act = digit_err ? ActSkip : ActDigit;
               end else if (is_op) begin
                  act = (state_q == StA && cnt != 2'd0) ? ActOp : ActSkip;
               end else if (is_term) begin
                  act = (state_q == StB && cnt != 2'd0) ? ActCalc : ActErrOut;
               end else begin
                  act = ActSkip;
               end
            end
            StSkip: if (is_term) act = ActErrOut;
            default: act = ActNone;
         endcase
      end
   end

   logic signed [16:0] a_ext, b_ext, calc;
   assign a_ext = $signed({9'd0, a_q});
   assign b_ext = $signed({9'd0, b_q});
   always_comb begin
      case (op_q)
         2'd0:    calc = a_ext + b_ext;
         2'd1:    calc = a_ext - b_ext;
         default: calc = a_ext * b_ext;
      endcase
   end

   logic [16:0] res_abs;
   logic [16:0] pow;
   assign res_abs = res_q[16] ? 17'(-res_q) : 17'(res_q);
   always_comb begin
      case (place_q)
         3'd1:    pow = 17'd10000;
         3'd2:    pow = 17'd1000;
         3'd3:    pow = 17'd100;
         3'd4:    pow = 17'd10;
         default: pow = 17'd0;
      endcase
   end

   logic [2:0] l0, l1, l2;
   assign l0 = len_q[2:0];
   assign l1 = l0 + 3'd1;
   assign l2 = l0 + 3'd2;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= StA;
         a_q        <= '0;
         b_q        <= '0;
         a_cnt_q    <= '0;
         b_cnt_q    <= '0;
         op_q       <= '0;
         res_q      <= '0;
         mag_q      <= '0;
         place_q    <= '0;
         digit_q    <= '0;
         started_q  <= 1'b0;
         len_q      <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rx_drop_q  <= 1'b0;
         for (int i = 0; i < 8; i++) tx_buf_q[i] <= '0;
      end else begin
         tx_valid_q <= 1'b0;
         rx_drop_q  <= bus.rx_valid && busy_q;
         case (state_q)
            StA, StB, StSkip: begin
               case (act)
                  ActDigit: begin
                     if (state_q == StB) begin
                        b_q     <= acc_next[7:0];
                        b_cnt_q <= b_cnt_q + 2'd1;
                     end else begin
                        a_q     <= acc_next[7:0];
                        a_cnt_q <= a_cnt_q + 2'd1;
                     end
                  end
                  ActOp: begin
                     op_q    <= op_code;
                     state_q <= StB;
                  end
                  ActCalc: begin
                     busy_q  <= 1'b1;
                     state_q <= StCalc;
                  end
                  ActSkip: state_q <= StSkip;
                  ActErrOut: begin
                     tx_buf_q[0] <= 8'h45;
                     tx_buf_q[1] <= 8'h0D;
                     tx_buf_q[2] <= 8'h0A;
                     len_q       <= 4'd3;
                     idx_q       <= '0;
                     gap_q       <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= StSend;
                  end
                  default: ;
               endcase
            end
            StCalc: begin
               res_q     <= calc;
               place_q   <= '0;
               len_q     <= '0;
               digit_q   <= '0;
               started_q <= 1'b0;
               state_q   <= StConv;
            end
            StConv: begin
               if (place_q == 3'd0) begin
                  if (res_q[16]) begin
                     tx_buf_q[0] <= 8'h2D;
                     len_q       <= 4'd1;
                  end
                  mag_q   <= res_abs;
                  place_q <= 3'd1;
               end else if (place_q <= 3'd4) begin
                  if (mag_q >= pow) begin
                     mag_q   <= mag_q - pow;
                     digit_q <= digit_q + 4'd1;
                  end else begin
                     // Leading zeros are dropped until the first non-zero digit
                     if (digit_q != 4'd0 || started_q) begin
                        tx_buf_q[l0] <= {4'h3, digit_q};
                        len_q        <= len_q + 4'd1;
                        started_q    <= 1'b1;
                     end
                     digit_q <= '0;
                     place_q <= place_q + 3'd1;
                  end
               end else begin
                  // Units digit is always emitted, so a zero result reads "0"
                  tx_buf_q[l0] <= {4'h3, mag_q[3:0]};
                  tx_buf_q[l1] <= 8'h0D;
                  tx_buf_q[l2] <= 8'h0A;
                  len_q        <= len_q + 4'd3;
                  idx_q        <= '0;
                  gap_q        <= '0;
                  state_q      <= StSend;
               end
            end
            StSend: begin
               if (gap_q == '0) begin
                  if (idx_q < len_q) begin
                     tx_valid_q <= 1'b1;
                     tx_data_q  <= tx_buf_q[idx_q[2:0]];
                     idx_q      <= idx_q + 4'd1;
                     gap_q      <= GapReload;
                  end else begin
                     // Final byte's frame time has elapsed
                     state_q <= StA;
                     busy_q  <= 1'b0;
                     a_q     <= '0;
                     b_q     <= '0;
                     a_cnt_q <= '0;
                     b_cnt_q <= '0;
                  end
               end else begin
                  gap_q <= gap_q - 32'd1;
               end
            end
            default: state_q <= StA;
         endcase
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.busy     = busy_q;
   assign bus.rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Self-checking bench for uart_calc_ctrl: directed command strings, an expression-level
// reference model producing the expected reply, and a per-cycle monitor on the tx stream.
module tb_uart_calc_ctrl;
   localparam int unsigned BC = 16;

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   uart_calc_ctrl_if bus_if ();

   uart_calc_ctrl #(.BYTE_CYCLES(BC)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_fail = 0;
   int           cyc = 0;
   byte unsigned exp_q[$];
   int           term_cyc = 0;
   int           last_pulse_cyc = 0;
   int           pulse_cnt = 0;
   bit           resp_first = 1'b1;
   logic [7:0]   last_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: evaluate the expression text directly and format the reply string.
   function automatic string model(input string s);
      string        crlf = "\015\012";
      int           st = 0;  // 0 first operand, 1 second operand, 2 error seen
      int           a = 0, b = 0, na = 0, nb = 0, v = 0;
      byte unsigned op = 0;
      byte unsigned c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c == 8'h20) continue;
         if (c == 8'h0D || c == 8'h3D) begin
            if (st == 1 && nb > 0) begin
               if (op == 8'h2B) v = a + b;
               else if (op == 8'h2D) v = a - b;
               else v = a * b;
               return $sformatf("%0d%s", v, crlf);
            end
            return {"E", crlf};
         end
         if (st == 2) continue;
         if (c >= 8'h30 && c <= 8'h39) begin
            if (st == 0) begin
               if (na == 3 || a * 10 + (int'(c) - 48) > 255) st = 2;
               else begin a = a * 10 + int'(c) - 48; na++; end
            end else begin
               if (nb == 3 || b * 10 + (int'(c) - 48) > 255) st = 2;
               else begin b = b * 10 + int'(c) - 48; nb++; end
            end
         end else if ((c == 8'h2B || c == 8'h2D || c == 8'h2A) && st == 0 && na > 0) begin
            op = c;
            st = 1;
         end else begin
            st = 2;
         end
      end
      return "";
   endfunction

   // Monitor: every tx pulse must match the next expected byte, with exact spacing inside a
   // reply and bounded latency for the first byte; between pulses tx_data must hold.
   always @(negedge clk) begin
      if (!n_rst) begin
         last_data = bus_if.tx_data;
      end else if (bus_if.tx_valid) begin
         if (exp_q.size() == 0) begin
            check("tx_unexpected_pulse", 1, 0);
         end else begin
            check("tx_data", int'(bus_if.tx_data), int'(exp_q.pop_front()));
         end
         check("busy_during_tx", int'(bus_if.busy), 1);
         if (resp_first) check("first_tx_latency_le_60", int'((cyc - term_cyc) <= 60), 1);
         else check("tx_spacing", cyc - last_pulse_cyc, BC);
         resp_first = 1'b0;
         last_pulse_cyc = cyc;
         pulse_cnt++;
         last_data = bus_if.tx_data;
      end else begin
         check("tx_data_hold", int'(bus_if.tx_data), int'(last_data));
      end
   end

   // Called at a negedge; returns at the negedge right after the byte was sampled.
   task automatic send_byte(input byte unsigned b);
      bus_if.rx_data  = b;
      bus_if.rx_valid = 1'b1;
      @(negedge clk);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic issue_cmd(input string s);
      string r = model(s);
      for (int i = 0; i < r.len(); i++) exp_q.push_back(r[i]);
      resp_first = 1'b1;
      for (int i = 0; i < s.len() - 1; i++) begin
         send_byte(s[i]);
         @(negedge clk);
      end
      check("busy_before_term", int'(bus_if.busy), 0);
      send_byte(s[s.len() - 1]);
      term_cyc = cyc;
      check("busy_after_term", int'(bus_if.busy), 1);
   endtask

   task automatic wait_done();
      int k = 0;
      while (exp_q.size() != 0 && k < 10 * BC + 200) begin
         @(negedge clk);
         k++;
      end
      check("all_bytes_sent", exp_q.size(), 0);
      k = 0;
      while (bus_if.busy && k < 2 * BC + 10) begin
         @(negedge clk);
         k++;
      end
      check("busy_fall_after_last_gap", cyc - last_pulse_cyc, BC);
   endtask

   task automatic run_cmd(input string s, input string lit);
      check({"model_pin ", lit.substr(0, 0)}, int'(model(s) == lit), 1);
      issue_cmd(s);
      wait_done();
      @(negedge clk);
   endtask

   task automatic wait_pulse();
      int p0 = pulse_cnt;
      int k = 0;
      while (pulse_cnt == p0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("first_pulse_seen", int'(pulse_cnt != p0), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.rx_data  = '0;
      bus_if.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", int'(bus_if.tx_valid), 0);
      check("rst_tx_data", int'(bus_if.tx_data), 0);
      check("rst_busy", int'(bus_if.busy), 0);
      check("rst_rx_drop", int'(bus_if.rx_drop), 0);
      n_rst = 1'b1;
      @(negedge clk);

      run_cmd("12+34\015", "46\015\012");
      run_cmd("5 - 200=", "-195\015\012");
      run_cmd("7-7\015", "0\015\012");
      run_cmd("255*255\015", "65025\015\012");
      run_cmd("256+1\015", "E\015\012");
      run_cmd("1+\015", "E\015\012");
      run_cmd("1x2\015", "E\015\012");
      run_cmd("1234+1\015", "E\015\012");
      run_cmd("3+4\015", "7\015\012");
      run_cmd("10*10=", "100\015\012");
      run_cmd("+5\015", "E\015\012");
      run_cmd("0-255\015", "-255\015\012");

      // Byte arriving while busy is dropped and leaves the reply untouched
      issue_cmd("12+34\015");
      wait_pulse();
      repeat (3) @(negedge clk);
      send_byte(8'h31);
      check("rx_drop_pulse", int'(bus_if.rx_drop), 1);
      @(negedge clk);
      check("rx_drop_single", int'(bus_if.rx_drop), 0);
      wait_done();
      @(negedge clk);
      run_cmd("3+4\015", "7\015\012");

      // Reset in the middle of a reply aborts it immediately
      issue_cmd("255*255\015");
      wait_pulse();
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      check("midrst_tx_valid", int'(bus_if.tx_valid), 0);
      check("midrst_busy", int'(bus_if.busy), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("midrst_tx_data", int'(bus_if.tx_data), 0);
      n_rst = 1'b1;
      @(negedge clk);
      run_cmd("9*9\015", "81\015\012");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
